fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl_if.sv | 28 ++
 rtl/fifo_rd_ctrl.sv | 128 ++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Burst read handshake bundle: start/len control, upstream FIFO read
// port and the downstream valid/ready stream.
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) ();
    logic                  start;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  busy;
    logic                  done;
    logic                  fifo_empty;
    logic                  fifo_rd_cs;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  start, burst_len, fifo_empty, fifo_data, out_ready,
        output busy, done, fifo_rd_cs, fifo_rd_en, out_valid, out_data
    );

    modport master (
        output start, burst_len, fifo_empty, fifo_data, out_ready,
        input  busy, done, fifo_rd_cs, fifo_rd_en, out_valid, out_data
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Burst reader: pulls burst_len words from a synchronous FIFO into a
// 2-entry skid buffer and streams them out on valid/ready.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    fifo_rd_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, issued_q, deliv_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf0_q, buf1_q, buf0_d, buf1_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            occ;
    logic                  valid, pop, rd, accept, last_hs;

    assign valid   = (cnt_q != 2'd0);
    assign pop     = valid && bus.out_ready;
    assign occ     = cnt_q + {1'b0, inflight_q};
    assign accept  = (state_q == IDLE) && bus.start;
    assign last_hs = pop && (deliv_q == (len_q - LEN_ONE));

    // A same-cycle pop frees a slot, so a full pipe can still read.
    assign rd = (state_q == RUN) && !bus.fifo_empty
             && (issued_q < len_q)
             && ((occ < 2'd2) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_hs) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    assign bus.fifo_rd_cs = rd;
    assign bus.fifo_rd_en = rd;
    assign bus.out_valid  = valid;
    assign bus.out_data   = buf0_q;

    // buf0 is always the oldest word; a read returns data one cycle later.
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    buf0_d = bus.fifo_data;
                end else begin
                    buf1_d = bus.fifo_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    buf0_d = bus.fifo_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus.fifo_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            issued_q   <= '0;
            deliv_q    <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= 2'd0;
        end else begin
            if (accept) begin
                len_q    <= bus.burst_len;
                issued_q <= '0;
                deliv_q  <= '0;
            end else begin
                if (rd) begin
                    issued_q <= issued_q + LEN_ONE;
                end
                if (pop) begin
                    deliv_q <= deliv_q + LEN_ONE;
                end
            end
            inflight_q <= rd;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a FIFO model and a
// scoreboard monitor on the output stream.
module tb_fifo_rd_ctrl;
    localparam int DW = 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic stall = 1'b0;
    int outstanding = 0;
    int max_out = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Registered-output FIFO: data appears the cycle after a read.
    always @(posedge clk) begin
        if (!rst && bus.fifo_rd_en) begin
            checks++;
            if (fq.size() == 0) begin
                failures++;
                $display("FAIL fifo_underflow actual=read required=no_read");
            end else begin
                bus.fifo_data <= fq.pop_front();
            end
        end
    end

    always @(posedge clk) begin
        #2;
        bus.fifo_empty = (fq.size() == 0) || stall;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_data", int'(bus.out_data), int'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", int'(bus.out_data), -1);
                end else begin
                    chk("word", int'(bus.out_data), int'(exp_q.pop_front()));
                end
            end
            outstanding += int'(bus.fifo_rd_en)
                         - int'(bus.out_valid && bus.out_ready);
            if (outstanding > max_out) max_out = outstanding;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            logic [DW-1:0] w;
            w = base + DW'(k);
            fq.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic issue(input logic [LW-1:0] len);
        tick();
        bus.start     = 1'b1;
        bus.burst_len = len;
        smp();
    endtask

    task automatic wait_done(input int from, input int budget, output int at);
        at = -1;
        for (int i = from; i < from + budget && at < 0; i++) begin
            tick();
            bus.start = 1'b0;
            smp();
            if (bus.done) at = i;
        end
        if (at < 0) $display("FAIL done_timeout actual=none required=done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] rd_v, cs_v, ov_v, dn_v, bz_v;
        int at;
        int cnt;
        bus.start     = 1'b0;
        bus.burst_len = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) smp();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_rd_en", int'(bus.fifo_rd_en), 0);
        chk("rst_rd_cs", int'(bus.fifo_rd_cs), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_data", int'(bus.out_data), 0);
        tick();
        rst = 1'b0;

        // Four-word burst at full rate
        tick();
        load(4, 8'hA1);
        issue(8'd4);
        rd_v = '0; cs_v = '0; ov_v = '0; dn_v = '0; bz_v = '0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                tick();
                bus.start = 1'b0;
                smp();
            end
            rd_v[i] = bus.fifo_rd_en;
            cs_v[i] = bus.fifo_rd_cs;
            ov_v[i] = bus.out_valid;
            dn_v[i] = bus.done;
            bz_v[i] = bus.busy;
        end
        chk("b4_rd_en", int'(rd_v), 'h01E);
        chk("b4_rd_cs", int'(cs_v), 'h01E);
        chk("b4_valid", int'(ov_v), 'h078);
        chk("b4_done", int'(dn_v), 'h080);
        chk("b4_busy", int'(bz_v), 'h0FE);
        chk("b4_drained", exp_q.size(), 0);

        // Zero-length burst with data sitting in the FIFO
        tick();
        fq.push_back(8'h77);
        issue(8'd0);
        rd_v = '0; dn_v = '0; bz_v = '0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
                bus.start = 1'b0;
                smp();
            end
            rd_v[i] = bus.fifo_rd_en;
            dn_v[i] = bus.done;
            bz_v[i] = bus.busy;
        end
        chk("b0_rd_en", int'(rd_v), 0);
        chk("b0_done", int'(dn_v), 'h2);
        chk("b0_busy", int'(bz_v), 'h2);
        chk("b0_fifo_kept", fq.size(), 1);
        fq.delete();

        // Six words with a 5-cycle downstream stall
        tick();
        load(6, 8'h10);
        issue(8'd6);
        cnt = 0;
        at  = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            bus.start     = 1'b0;
            bus.out_ready = (i < 4 || i > 8);
            smp();
            if (i >= 4 && i <= 8) cnt += int'(bus.fifo_rd_en);
            if (i == 8) at = int'(bus.out_data);
        end
        chk("b6_stall_reads", cnt, 0);
        chk("b6_held_word", at, 'h11);
        wait_done(10, 30, at);
        chk("b6_done_cycle", at, 14);
        chk("b6_drained", exp_q.size(), 0);

        // FIFO runs dry after two of three words
        tick();
        load(2, 8'h30);
        exp_q.push_back(8'h32);
        issue(8'd3);
        cnt = 0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            bus.start = 1'b0;
            smp();
            if (i >= 3) cnt += int'(bus.fifo_rd_en) + int'(bus.done);
        end
        chk("dry_no_activity", cnt, 0);
        chk("dry_busy", int'(bus.busy), 1);
        tick();
        fq.push_back(8'h32);
        smp();
        wait_done(13, 20, at);
        chk("dry_done_cycle", at, 15);
        chk("dry_drained", exp_q.size(), 0);

        // Second start during RUN must be ignored
        tick();
        load(3, 8'h50);
        fq.push_back(8'h53);
        fq.push_back(8'h54);
        issue(8'd3);
        tick();
        bus.start = 1'b0;
        smp();
        tick();
        bus.start     = 1'b1;
        bus.burst_len = 8'd5;
        smp();
        wait_done(3, 20, at);
        chk("ign_done_cycle", at, 6);
        tick();
        smp();
        tick();
        smp();
        chk("ign_idle", int'(bus.busy), 0);
        chk("ign_fifo_left", fq.size(), 2);
        chk("ign_drained", exp_q.size(), 0);
        fq.delete();

        // Reset with one word buffered and one in flight
        tick();
        load(4, 8'h60);
        bus.out_ready = 1'b0;
        issue(8'd4);
        tick();
        bus.start = 1'b0;
        smp();
        tick();
        smp();
        tick();
        chk("mid_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_busy", int'(bus.busy), 0);
        chk("mid_done", int'(bus.done), 0);
        chk("mid_rd_en", int'(bus.fifo_rd_en), 0);
        chk("mid_rd_cs", int'(bus.fifo_rd_cs), 0);
        chk("mid_valid0", int'(bus.out_valid), 0);
        chk("mid_data", int'(bus.out_data), 0);
        fq.delete();
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        smp();
        chk("post_busy", int'(bus.busy), 0);
        chk("post_valid", int'(bus.out_valid), 0);

        // Maximum-length burst, counters must not wrap early
        tick();
        load(255, 8'h5A);
        issue(8'd255);
        wait_done(1, 300, at);
        chk("max_done_cycle", at, 258);
        chk("max_fifo_empty", fq.size(), 0);
        chk("max_drained", exp_q.size(), 0);
        chk("max_outstanding", max_out, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
